// File: rtl/perceptron_pkg.sv
// Shared types and saturation helpers for the perceptron accumulator.
// Holds the FSM state enum, the clamped-add helper and the signed limits.
package perceptron_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACCUM,
    S_DONE
  } acc_state_t;

  // Widest accumulator the helpers support; callers zero-extend
  // their W-bit operands and keep the low W bits of the result.
  localparam int W_MAX = 64;

  typedef struct packed {
    logic [W_MAX-1:0] val;
    logic             ovf;
  } sat_res_t;

  function automatic logic [W_MAX-1:0] sat_max(input int w);
    return (W_MAX'(1) << (w - 1)) - W_MAX'(1);
  endfunction

  function automatic logic [W_MAX-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

  // Clamp y = a + b (computed at width w) to the signed limits when
  // equal-signed operands produce a result of the opposite sign.
  function automatic sat_res_t sat_add_fix(
    input logic [W_MAX-1:0] a,
    input logic [W_MAX-1:0] b,
    input logic [W_MAX-1:0] y,
    input int               w
  );
    sat_res_t         r;
    logic [W_MAX-1:0] sh_a;
    logic [W_MAX-1:0] sh_b;
    logic [W_MAX-1:0] sh_y;
    sh_a  = a >> (w - 1);
    sh_b  = b >> (w - 1);
    sh_y  = y >> (w - 1);
    r.ovf = (sh_a[0] == sh_b[0]) &&
            (sh_y[0] != sh_a[0]);
    if (r.ovf) begin
      r.val = sh_a[0] ? sat_min(w) : sat_max(w);
    end else begin
      r.val = y;
    end
    return r;
  endfunction

endpackage

// File: rtl/float_adder.sv
// Fixed-point two's-complement adder, wrapping at W = SIGN+Q_M+Q_N.
// Ports: a_in, b_in (operands), y_out (wrapped sum).
module float_adder #(
  parameter  int SIGN = 1,
  parameter  int Q_M  = 16,
  parameter  int Q_N  = 16,
  localparam int W    = SIGN + Q_M + Q_N
) (
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] y_out
);

  assign y_out = a_in + b_in;

endmodule

// File: rtl/perceptron_accumulator.sv
// Sequencer forming bias + sum of N_INPUTS terms with saturation.
// Ports: clk_i/rst_i, start_i/bias_i, term stream in, sum stream out.
module perceptron_accumulator
  import perceptron_pkg::*;
#(
  parameter  int SIGN     = 1,
  parameter  int Q_M      = 16,
  parameter  int Q_N      = 16,
  parameter  int N_INPUTS = 4,
  localparam int W        = SIGN + Q_M + Q_N,
  localparam int CW       = $clog2(N_INPUTS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [W-1:0]  bias_i,
  input  logic          term_valid_i,
  input  logic [W-1:0]  term_i,
  output logic          term_ready_o,
  output logic          busy_o,
  output logic          sum_valid_o,
  output logic [W-1:0]  sum_o,
  input  logic          sum_ready_i,
  output logic          overflow_o,
  output logic [CW-1:0] count_o
);

  acc_state_t    state_q, state_d;
  logic [W-1:0]  bias_q, bias_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          rdy_q, busy_q, vld_q;

  logic [W-1:0]         add_y;
  sat_res_t             sat;
  logic [W_MAX-W-1:0]   sat_unused;

  float_adder #(
    .SIGN (SIGN),
    .Q_M  (Q_M),
    .Q_N  (Q_N)
  ) u_add (
    .a_in  (acc_q),
    .b_in  (term_i),
    .y_out (add_y)
  );

  assign sat = sat_add_fix(W_MAX'(acc_q),
                           W_MAX'(term_i),
                           W_MAX'(add_y), W);
  assign sat_unused = sat.val[W_MAX-1:W];

  always_comb begin
    state_d = state_q;
    bias_d  = bias_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          bias_d  = bias_i;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        acc_d   = bias_q;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (term_valid_i && rdy_q) begin
          acc_d = sat.val[W-1:0];
          ovf_d = ovf_q | sat.ovf;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N_INPUTS - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (sum_ready_i) begin
          if (start_i) begin
            state_d = S_LOAD;
            bias_d  = bias_i;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they
  // line up with state_q without any combinational path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      bias_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= (state_d == S_ACCUM);
      busy_q  <= (state_d == S_LOAD) ||
                 (state_d == S_ACCUM);
      vld_q   <= (state_d == S_DONE);
    end
  end

  assign term_ready_o = rdy_q;
  assign busy_o       = busy_q;
  assign sum_valid_o  = vld_q;
  assign sum_o        = acc_q;
  assign overflow_o   = ovf_q;
  assign count_o      = cnt_q;

endmodule

// File: tb/tb_perceptron_accumulator.sv
// Directed bench for perceptron_accumulator, W=33, N_INPUTS=4.
// Each scenario task drives stimulus and checks its own results.
module tb_perceptron_accumulator;

  localparam int W  = 33;
  localparam int CW = 3;

  typedef logic [W-1:0] w_t;

  localparam w_t MAXV = 33'h0_FFFF_FFFF;
  localparam w_t MINV = 33'h1_0000_0000;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  w_t            bias_i = '0;
  logic          term_valid_i = 1'b0;
  w_t            term_i = '0;
  logic          term_ready_o;
  logic          busy_o;
  logic          sum_valid_o;
  w_t            sum_o;
  logic          sum_ready_i = 1'b0;
  logic          overflow_o;
  logic [CW-1:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  perceptron_accumulator #(
    .SIGN     (1),
    .Q_M      (16),
    .Q_N      (16),
    .N_INPUTS (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .bias_i       (bias_i),
    .term_valid_i (term_valid_i),
    .term_i       (term_i),
    .term_ready_o (term_ready_o),
    .busy_o       (busy_o),
    .sum_valid_o  (sum_valid_o),
    .sum_o        (sum_o),
    .sum_ready_i  (sum_ready_i),
    .overflow_o   (overflow_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in the LOAD cycle; streams four terms back to back and
  // returns in the cycle where DONE is expected (cycle 6).
  task automatic stream4(input w_t t0, input w_t t1,
                         input w_t t2, input w_t t3,
                         output logic early);
    w_t ts [4];
    ts[0] = t0; ts[1] = t1; ts[2] = t2; ts[3] = t3;
    early = 1'b0;
    term_valid_i = 1'b1;
    term_i = ts[0];
    cyc();
    early = early | sum_valid_o;
    for (int k = 1; k < 4; k++) begin
      cyc();
      early = early | sum_valid_o;
      term_i = ts[k];
    end
    cyc();
    term_valid_i = 1'b0;
    term_i = '0;
  endtask

  task automatic run4(input w_t b, input w_t t0, input w_t t1,
                      input w_t t2, input w_t t3,
                      output logic early);
    start_i = 1'b1;
    bias_i  = b;
    cyc();
    start_i = 1'b0;
    stream4(t0, t1, t2, t3, early);
  endtask

  task automatic accept();
    sum_ready_i = 1'b1;
    cyc();
    sum_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    n_checks++;
    if ({busy_o, term_ready_o, sum_valid_o, overflow_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy_o, term_ready_o, sum_valid_o, overflow_o});
    end
    n_checks++;
    if (sum_o !== '0 || count_o !== '0) begin
      n_fail++;
      $display("FAIL reset_sum: got sum %0d cnt %0d want 0 0",
               sum_o, count_o);
    end
  endtask

  task automatic test_basic();
    logic early;
    start_i = 1'b1;
    bias_i  = '0;
    cyc();
    start_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1 || term_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_flags: got busy %b rdy %b want 1 0",
               busy_o, term_ready_o);
    end
    stream4(w_t'(123), w_t'(146), -w_t'(123), w_t'(10), early);
    n_checks++;
    if (early !== 1'b0 || sum_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got early %b vld %b want 0 1",
               early, sum_valid_o);
    end
    n_checks++;
    if (sum_o !== w_t'(156) || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: got %0d ovf %b want 156 0",
               $signed(sum_o), overflow_o);
    end
    n_checks++;
    if (count_o !== 3'd4 || term_ready_o !== 1'b0 ||
        busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got cnt %0d rdy %b busy %b want 4 0 0",
               count_o, term_ready_o, busy_o);
    end
    accept();
    n_checks++;
    if (sum_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got vld %b busy %b want 0 0",
               sum_valid_o, busy_o);
    end
  endtask

  task automatic test_neg_bias();
    logic early;
    run4(-w_t'(146), '0, '0, '0, '0, early);
    n_checks++;
    if (sum_valid_o !== 1'b1 || sum_o !== -w_t'(146)) begin
      n_fail++;
      $display("FAIL neg_bias: got vld %b sum %0d want 1 -146",
               sum_valid_o, $signed(sum_o));
    end
    accept();
  endtask

  task automatic test_saturation();
    logic early;
    run4(MAXV, w_t'(1), '0, '0, '0, early);
    n_checks++;
    if (sum_o !== MAXV || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pos: got %h ovf %b want %h 1",
               sum_o, overflow_o, MAXV);
    end
    accept();
    run4(MINV, -w_t'(1), '0, '0, '0, early);
    n_checks++;
    if (sum_o !== MINV || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg: got %h ovf %b want %h 1",
               sum_o, overflow_o, MINV);
    end
    accept();
  endtask

  task automatic test_backpressure();
    w_t   bp [4];
    int   k;
    logic ph;
    logic acc;
    bp[0] = w_t'(123); bp[1] = w_t'(146);
    bp[2] = -w_t'(123); bp[3] = w_t'(10);
    start_i = 1'b1;
    bias_i  = '0;
    cyc();
    start_i = 1'b0;
    k  = 0;
    ph = 1'b0;
    for (int i = 0; i < 40 && !sum_valid_o; i++) begin
      term_valid_i = ph && (k < 4);
      term_i = (k < 4) ? bp[k] : '0;
      acc = term_valid_i && term_ready_o;
      cyc();
      if (acc) k++;
      ph = !ph;
    end
    term_valid_i = 1'b0;
    n_checks++;
    if (sum_valid_o !== 1'b1 || k != 4) begin
      n_fail++;
      $display("FAIL bp_done: got vld %b terms %0d want 1 4",
               sum_valid_o, k);
    end
    for (int i = 0; i < 3; i++) begin
      term_valid_i = 1'b1;
      term_i = w_t'(77);
      n_checks++;
      if (sum_o !== w_t'(156) || sum_valid_o !== 1'b1 ||
          term_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: got sum %0d vld %b rdy %b want 156 1 0",
                 $signed(sum_o), sum_valid_o, term_ready_o);
      end
      cyc();
    end
    term_valid_i = 1'b0;
    n_checks++;
    if (sum_o !== w_t'(156) || count_o !== 3'd4) begin
      n_fail++;
      $display("FAIL bp_sum: got %0d cnt %0d want 156 4",
               $signed(sum_o), count_o);
    end
    accept();
    n_checks++;
    if (sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got vld %b want 0", sum_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic early;
    start_i = 1'b1;
    bias_i  = w_t'(40);
    cyc();
    start_i = 1'b0;
    term_valid_i = 1'b1;
    term_i = w_t'(7);
    cyc();
    cyc();
    cyc();
    n_checks++;
    if (count_o !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_count: got %0d want 2", count_o);
    end
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    term_valid_i = 1'b0;
    n_checks++;
    if (sum_o !== '0 || count_o !== '0 || overflow_o !== 1'b0 ||
        busy_o !== 1'b0 || term_ready_o !== 1'b0 ||
        sum_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got sum %0d cnt %0d flags %b%b%b%b want 0",
               sum_o, count_o, overflow_o, busy_o,
               term_ready_o, sum_valid_o);
    end
    run4(w_t'(5), w_t'(1), w_t'(1), w_t'(1), w_t'(1), early);
    n_checks++;
    if (sum_valid_o !== 1'b1 || sum_o !== w_t'(9)) begin
      n_fail++;
      $display("FAIL mid_fresh: got vld %b sum %0d want 1 9",
               sum_valid_o, $signed(sum_o));
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic early;
    start_i = 1'b1;
    bias_i  = MAXV - w_t'(2);
    cyc();
    start_i = 1'b0;
    term_valid_i = 1'b1;
    term_i = w_t'(1);
    cyc();
    cyc();
    start_i = 1'b1;
    bias_i  = '0;
    cyc();
    start_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1 || term_ready_o !== 1'b1 ||
        count_o !== 3'd2) begin
      n_fail++;
      $display("FAIL start_ignored: got busy %b rdy %b cnt %0d want 1 1 2",
               busy_o, term_ready_o, count_o);
    end
    cyc();
    cyc();
    term_valid_i = 1'b0;
    n_checks++;
    if (sum_valid_o !== 1'b1 || sum_o !== MAXV ||
        overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL first_sum: got vld %b sum %h ovf %b want 1 %h 1",
               sum_valid_o, sum_o, overflow_o, MAXV);
    end
    start_i     = 1'b1;
    sum_ready_i = 1'b1;
    bias_i      = w_t'(20);
    cyc();
    start_i     = 1'b0;
    sum_ready_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1 || sum_valid_o !== 1'b0 ||
        overflow_o !== 1'b0 || count_o !== '0 ||
        term_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load: got busy %b vld %b ovf %b cnt %0d rdy %b",
               busy_o, sum_valid_o, overflow_o, count_o, term_ready_o);
    end
    stream4(w_t'(1), w_t'(2), w_t'(3), w_t'(4), early);
    n_checks++;
    if (sum_valid_o !== 1'b1 || sum_o !== w_t'(30) ||
        overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_sum: got vld %b sum %0d ovf %b want 1 30 0",
               sum_valid_o, $signed(sum_o), overflow_o);
    end
    accept();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_neg_bias();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/perceptron_accumulator.md
# perceptron_accumulator

Sequencer that drives the team's fixed-point `float_adder` to form one perceptron pre-activation sum: `bias + Σ term[k]` for `N_INPUTS` terms. Terms arrive over a valid/ready stream, typically from the multiplier stage. Each term is folded into a saturating accumulator, one per cycle. The block hands the finished sum downstream over a valid/ready output held until accepted. It sits between the weight×input product stage and the activation function.

## Interface
- `SIGN`, default 1, sign bit count; passed to `float_adder`.
- `Q_M`, default 16, integer bits.
- `Q_N`, default 16, fraction bits.
- `N_INPUTS`, default 4, terms per sum; legal range is 1 or more.
- `W`, derived as `SIGN+Q_M+Q_N`; not overridable.

- `clk_i`  in  1  sole clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin a new sum; honoured only in IDLE or DONE.
- `bias_i`  in  W  two's-complement bias; sampled on the accepted `start_i` cycle.
- `term_valid_i`  in  1  term available.
- `term_i`  in  W  two's-complement term.
- `term_ready_o`  out  1  high only in ACCUM.
- `busy_o`  out  1  high in LOAD and ACCUM.
- `sum_valid_o`  out  1  high only in DONE.
- `sum_o`  out  W  accumulator value; final when `sum_valid_o`.
- `sum_ready_i`  in  1  downstream accepts the sum.
- `overflow_o`  out  1  sticky; set if any add in the current sum saturated.
- `count_o`  out  $clog2(N_INPUTS+1)  terms accepted so far.

## Operation
- The FSM has four states: IDLE, LOAD, ACCUM and DONE.
- IDLE → LOAD on `start_i`:
  - latch `bias_i`;
  - clear `count_o` and `overflow_o`.
- LOAD:
  - `acc <= bias`;
  - go to ACCUM unconditionally.
- ACCUM:
  - on `term_valid_i && term_ready_o`, `acc <= sat(acc + term_i)` and `count++`;
  - when the N_INPUTS-th term is accepted, go to DONE.
- DONE:
  - `sum_o`, `overflow_o` and `sum_valid_o` are held stable;
  - on `sum_ready_i` alone, go to IDLE;
  - on `sum_ready_i && start_i` in the same cycle, go to LOAD with the new bias (back-to-back).
- `start_i` in LOAD or ACCUM is ignored. It is not queued.
- `start_i` in DONE without `sum_ready_i` is ignored.
- Arithmetic is two's complement at width W, and the add is performed by `float_adder`:
  - `a_in = acc`, `b_in = term_i`.
- Saturation rule:
  - if the operands share a sign and `y_out` has the opposite sign, the result clamps to the signed limit: `+2^(W-1)-1` or `-2^(W-1)`;
  - a clamped add sets `overflow_o`;
  - otherwise the result is `y_out` unchanged.
- Once set, `overflow_o` stays set until the next accepted start.

## Timing
- Reset (`rst_i` high at an edge) puts the block in IDLE and forces:
  - `acc`, `sum_o`, `count_o`, `overflow_o` = 0;
  - `term_ready_o`, `sum_valid_o`, `busy_o` = 0.
- Reset wins over every other input in the same cycle, including mid-ACCUM. A partial sum is discarded.
- `float_adder` is used combinationally. The accumulator register adds one cycle per term.
- Minimum latency: `start_i` accepted at cycle 0 → LOAD at cycle 1 → terms accepted in cycles 2..N+1 → `sum_valid_o` at cycle N+2.
  - For `N_INPUTS`=4, `sum_valid_o` is at cycle 6.
- Term stream:
  - gaps in `term_valid_i` stall ACCUM without penalty;
  - `term_ready_o` does not depend on `term_valid_i`;
  - no term is accepted outside ACCUM.
- Output stream:
  - `sum_valid_o` stays high until `sum_ready_i` is seen;
  - `sum_o` does not change while `sum_valid_o` is high.
- `N_INPUTS`=1 is legal: exactly one term is accepted, then DONE.

## Structure
- Package `perceptron_pkg` holds:
  - the `acc_state_t` enum;
  - function `sat_add_fix(a, b, y)` returning the clamped value plus an overflow bit;
  - `W`-derived min/max constants.
- One sub-module instance: the existing `float_adder`, with `SIGN`/`Q_M`/`Q_N` passed through.
- No additional sub-modules.

## Test plan
All values below are raw integers, W=33, N_INPUTS=4.
1. Basic sum: bias 0, terms 123, 146, -123, 10 streamed back-to-back → `sum_o`=156, `overflow_o`=0, `sum_valid_o` at cycle 6.
2. Negative bias, zero terms: bias -146, terms 0, 0, 0, 0 → `sum_o`=-146.
3. Saturation: bias 2^32-1, terms 1, 0, 0, 0 → `sum_o`=2^32-1, `overflow_o`=1. A negative case with bias -2^32 and term -1 → `sum_o`=-2^32, `overflow_o`=1.
4. Backpressure:
   - `term_valid_i` toggles every other cycle and `sum_ready_i` is held low 3 cycles → same result as scenario 1;
   - `sum_o` is stable while waiting and `term_ready_o`=0 in DONE.
5. Reset mid-ACCUM: assert `rst_i` after 2 terms → next cycle shows IDLE with all outputs 0; a fresh start with bias 5 and terms 1, 1, 1, 1 → `sum_o`=9.
6. Control edges:
   - `start_i` pulsed during ACCUM is ignored and the sum is unchanged;
   - `start_i` and `sum_ready_i` together in DONE → LOAD next cycle;
   - that second sum is accepted with `overflow_o` cleared.
